// File: rtl/i2s_master_tx.sv
// i2s_master_tx: Philips I2S master transmitter deriving BCLK/LRCLK from MCLK,
// with a one-pair holding register that feeds the active shift words at each frame boundary.
module i2s_master_tx #(
    parameter int BITSIZE  = 16,
    parameter int MCLK_DIV = 4,
    parameter int SLOT     = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [BITSIZE-1:0] in_l,
    input  logic [BITSIZE-1:0] in_r,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               bclk,
    output logic               lrclk,
    output logic               sdata,
    output logic               frame_start,
    output logic               underrun
);
    localparam int DW = $clog2(MCLK_DIV);
    localparam int BW = $clog2(2 * SLOT);
    localparam int IW = $clog2(BITSIZE);

    logic [DW-1:0]      div_cnt_q, div_cnt_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic               bclk_q, bclk_d;
    logic               lrclk_q, lrclk_d;
    logic               sdata_q, sdata_d;
    logic               frame_start_q, frame_start_d;
    logic               underrun_q, underrun_d;
    logic               hold_full_q, hold_full_d;
    logic [BITSIZE-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [BITSIZE-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
    logic               fall, boundary, accept;
    logic [BW-1:0]      s;
    logic [IW-1:0]      idx;
    logic [BITSIZE-1:0] word;

    always_comb begin
        fall          = div_cnt_q == DW'(MCLK_DIV - 1);
        boundary      = fall && bit_cnt_q == BW'(2 * SLOT - 1);
        accept        = in_valid && !hold_full_q;
        div_cnt_d     = fall ? '0 : div_cnt_q + DW'(1);
        bit_cnt_d     = !fall ? bit_cnt_q : boundary ? '0 : bit_cnt_q + BW'(1);
        bclk_d        = div_cnt_d >= DW'(MCLK_DIV / 2);
        lrclk_d       = bit_cnt_d >= BW'(SLOT);
        // s = position within the slot; slot bit 0 is the Philips one-bit delay
        s             = lrclk_d ? bit_cnt_d - BW'(SLOT) : bit_cnt_d;
        idx           = IW'(BW'(BITSIZE) - s);
        word          = lrclk_d ? act_r_q : act_l_q;
        sdata_d       = fall ? (s != '0 && s <= BW'(BITSIZE)) && word[idx] : sdata_q;
        frame_start_d = boundary;
        underrun_d    = boundary && !hold_full_q;
        act_l_d       = boundary ? (hold_full_q ? hold_l_q : '0) : act_l_q;
        act_r_d       = boundary ? (hold_full_q ? hold_r_q : '0) : act_r_q;
        hold_l_d      = accept ? in_l : hold_l_q;
        hold_r_d      = accept ? in_r : hold_r_q;
        // a pair captured on an empty boundary survives into the next frame
        hold_full_d   = accept || (hold_full_q && !boundary);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            act_l_q       <= '0;
            act_r_q       <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            hold_full_q   <= hold_full_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            act_l_q       <= act_l_d;
            act_r_q       <= act_r_d;
        end
    end

    assign in_ready    = !hold_full_q;
    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_master_tx.sv
// tb_i2s_master_tx: randomized I2S master stimulus; a frame-level model queues the expected
// frames and a monitor rebuilds each frame from BCLK rising-edge samples and compares.
module tb_i2s_master_tx;
    localparam int BITSIZE  = 16;
    localparam int MCLK_DIV = 4;
    localparam int SLOT     = 32;
    localparam int FRAME    = 2 * SLOT * MCLK_DIV;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        ur;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [15:0] in_l = '0, in_r = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, bclk, lrclk, sdata, frame_start, underrun;
    int          errors = 0, checks = 0;
    exp_t        expq[$];
    int          cyc = 0;
    bit          full = 1'b0;
    logic [15:0] hl = '0, hr = '0;

    i2s_master_tx #(.BITSIZE(BITSIZE), .MCLK_DIV(MCLK_DIV), .SLOT(SLOT)) dut (
        .clk(clk), .resetn(resetn), .in_l(in_l), .in_r(in_r), .in_valid(in_valid),
        .in_ready(in_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .frame_start(frame_start), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected 64-bit frame, first transmitted bit in the MSB
    function automatic logic [63:0] frame_bits(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] f;
        logic [15:0] w;
        int          s;
        f = '0;
        for (int t = 0; t < 2 * SLOT; t++) begin
            s = t % SLOT;
            w = (t < SLOT) ? l : r;
            if (s >= 1 && s <= BITSIZE) f[2*SLOT-1-t] = w[BITSIZE-s];
        end
        return f;
    endfunction

    task automatic check_reset();
        chk("reset_bclk", bclk, 0);
        chk("reset_lrclk", lrclk, 0);
        chk("reset_sdata", sdata, 0);
        chk("reset_frame_start", frame_start, 0);
        chk("reset_underrun", underrun, 0);
        chk("reset_in_ready", in_ready, 1);
    endtask

    // mode 0: sparse random offers, 1: always offering, 2: never, 3: offer only on boundary clk
    task automatic drive(input int n, input int mode, input bit fixed);
        int   e;
        bit   hs;
        exp_t x;
        for (int i = 0; i < n; i++) begin
            e    = cyc + 1;
            in_l = fixed ? 16'h8001 : 16'($urandom);
            in_r = fixed ? 16'h7FFE : 16'($urandom);
            case (mode)
                0:       in_valid = ($urandom_range(0, 299) == 0);
                1:       in_valid = 1'b1;
                2:       in_valid = 1'b0;
                default: in_valid = (e % FRAME == 0);
            endcase
            if (cyc < 8) in_valid = 1'b1;
            chk("in_ready", in_ready, !full);
            if (cyc < SLOT * MCLK_DIV) chk("lrclk_after_reset", lrclk, 0);
            if (cyc < FRAME) chk("sdata_after_reset", sdata, 0);
            hs = in_valid && !full;
            if (e % FRAME == 0) begin
                x.l  = full ? hl : 16'h0;
                x.r  = full ? hr : 16'h0;
                x.ur = !full;
                expq.push_back(x);
                full = 1'b0;
            end
            if (hs) begin
                full = 1'b1;
                hl   = in_l;
                hr   = in_r;
            end
            cyc = e;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] cap, lcap;
        int          nbits, since_fs, since_rise, hi_len;
        bit          armed, bclk_prev;
        exp_t        cur;
        cap = '0; lcap = '0; nbits = 0; since_fs = 0; since_rise = 0; hi_len = 0;
        armed = 1'b0; bclk_prev = 1'b0;
        cur.l = '0; cur.r = '0; cur.ur = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                armed = 1'b0; bclk_prev = 1'b0; nbits = 0; hi_len = 0;
            end else begin
                since_fs++;
                since_rise++;
                if (bclk) hi_len++;
                if (bclk && !bclk_prev) begin
                    if (armed && nbits > 0) chk("bclk_period", since_rise, MCLK_DIV);
                    since_rise = 0;
                    hi_len     = 1;
                    cap        = {cap[62:0], sdata};
                    lcap       = {lcap[62:0], lrclk};
                    nbits++;
                end
                if (!bclk && bclk_prev) begin
                    if (armed) chk("bclk_high", hi_len, MCLK_DIV / 2);
                    hi_len = 0;
                end
                bclk_prev = bclk;
                if (frame_start) begin
                    if (armed) begin
                        chk("frame_period", since_fs, FRAME);
                        chk("frame_nbits", nbits, 2 * SLOT);
                        chk("frame_data", cap, frame_bits(cur.l, cur.r));
                        chk("lrclk_frame", lcap, {{SLOT{1'b0}}, {SLOT{1'b1}}});
                    end
                    if (expq.size() == 0) chk("scoreboard_empty", 1, 0);
                    else begin
                        cur = expq.pop_front();
                        chk("underrun", underrun, cur.ur);
                    end
                    armed = 1'b1; since_fs = 0; nbits = 0; cap = '0; lcap = '0;
                end else if (armed && underrun) chk("underrun_stray", 1, 0);
            end
        end
    end

    initial begin
        #2 resetn = 1'b0;
        #1 check_reset();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        cyc    = 0;
        full   = 1'b0;
        drive(300, 1, 1'b1);
        drive(700, 2, 1'b0);
        drive(1000, 1, 1'b0);
        drive(3 * FRAME, 3, 1'b0);
        drive(3000, 0, 1'b0);
        drive(FRAME + 200 - cyc % FRAME, 0, 1'b0);
        chk("lrclk_right_slot", lrclk, 1);
        #3 resetn = 1'b0;
        in_valid = 1'b0;
        #1 check_reset();
        @(negedge clk);
        @(negedge clk);
        expq.delete();
        full   = 1'b0;
        cyc    = 0;
        resetn = 1'b1;
        drive(1500, 0, 1'b0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2s_master_tx.md
I2S_MASTER_TX -- requirements
Module: i2s_master_tx

Interface
REQ-001 SHALL have parameter BITSIZE, default 16, audio sample width in bits.
REQ-002 SHALL have parameter MCLK_DIV, default 4, clk cycles per BCLK period; even, >=2.
REQ-003 SHALL have parameter SLOT, default 32, BCLK periods per channel slot; SLOT > BITSIZE.
REQ-004 SHALL have port clk  input  1  single clock, the codec MCLK (12.288 MHz); all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_l  input  BITSIZE  left sample, two's complement.
REQ-007 SHALL have port in_r  input  BITSIZE  right sample, two's complement.
REQ-008 SHALL have port in_valid  input  1  sample pair offered.
REQ-009 SHALL have port in_ready  output  1  holding register empty.
REQ-010 SHALL have port bclk  output  1  generated bit clock.
REQ-011 SHALL have port lrclk  output  1  generated word select; 0 = left, 1 = right.
REQ-012 SHALL have port sdata  output  1  serial data to codec DACDAT.
REQ-013 SHALL have port frame_start  output  1  one-clk pulse at each frame boundary.
REQ-014 SHALL have port underrun  output  1  one-clk pulse when a frame boundary finds the holding register empty.

Function
REQ-015 SHALL count clk cycles in div_cnt, 0..MCLK_DIV-1, wrapping.
REQ-016 SHALL drive bclk = 1 when div_cnt >= MCLK_DIV/2, else 0, registered, so the BCLK duty cycle is 50%.
REQ-017 SHALL define the BCLK falling edge as the clk edge where div_cnt wraps from MCLK_DIV-1 to 0.
REQ-018 SHALL count bit_cnt, 0..2*SLOT-1, incrementing only at BCLK falling edges, wrapping.
REQ-019 SHALL update lrclk, sdata and bit_cnt only at BCLK falling edges; the codec samples on rising edges.
REQ-020 SHALL drive lrclk = 0 for bit_cnt < SLOT and 1 otherwise.
REQ-021 SHALL use Philips I2S alignment, with s = bit_cnt mod SLOT:
- s = 1..BITSIZE carries the word MSB first (left word in the left slot, right word in the right slot).
- s = 0 and s > BITSIZE carry 0.
REQ-022 SHALL define the frame boundary as the BCLK falling edge where bit_cnt wraps from 2*SLOT-1 to 0.
REQ-023 SHALL pulse frame_start at the frame boundary.
REQ-024 SHALL hold one {in_l, in_r} pair in a holding register; in_ready = NOT hold_full.
REQ-025 SHALL capture in_l/in_r and set hold_full on any clk edge where in_valid && in_ready.
REQ-026 SHALL handle the frame boundary as follows:
- if hold_full: copy the holding register into the active left/right registers and clear hold_full;
- else: load zeros into the active registers and pulse underrun.
REQ-027 SHALL, when a handshake coincides with the frame boundary while hold_full = 0:
- signal underrun and transmit zeros for that frame;
- keep the newly captured pair in the holding register for the next frame.
REQ-028 SHALL ignore in_valid while hold_full = 1, so no data is overwritten.
REQ-029 SHALL keep in_l/in_r changes after acceptance out of the transmitted frame.
REQ-030 SHALL transmit an accepted pair starting at the next frame boundary; the left MSB appears on sdata 1 BCLK after that boundary.
REQ-031 SHALL have a frame period of 2*SLOT*MCLK_DIV clk cycles; 256 at defaults, giving 48 kHz.

Reset
REQ-032 SHALL, while resetn = 0, asynchronously force:
- div_cnt = 0 and bit_cnt = 0;
- bclk = 0, lrclk = 0, sdata = 0;
- frame_start = 0, underrun = 0;
- hold_full = 0 (so in_ready = 1) and active registers = 0.
REQ-033 SHALL, after reset release, start counting on the first clk edge and transmit zeros until the first frame boundary.
REQ-034 SHALL NOT pulse underrun for the partial first frame after reset.
REQ-035 SHALL, on reset mid-frame, discard the holding and active contents and restart from bit_cnt = 0.

Verification
REQ-036 Free-run at defaults -> bclk period 4 clk with 2 high and 2 low; lrclk period 256 clk; frame_start exactly every 256 clk.
REQ-037 Accept in_l=16'h8001, in_r=16'h7FFE before a boundary -> after the boundary sdata is 0,1,0..0,1 (left, s=1..16) then zeros; in the right slot 0,0111..1110, then zeros.
REQ-038 No data offered at a boundary -> underrun pulses for 1 clk; all 64 bits of the frame are 0; in_ready stays 1.
REQ-039 in_valid held high continuously with new values -> one pair accepted per frame; in_ready low from acceptance until the next boundary; no underrun.
REQ-040 Handshake on the exact boundary clk with the holding register empty -> underrun, zero frame, and that pair is sent in the following frame.
REQ-041 Assert resetn = 0 mid right slot -> all outputs 0 immediately; in_ready = 1; lrclk stays low for the first 128 clk after release.
